// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared definitions for the SD CMD-line sequencer: command fields, response codes,
// status bit positions, FSM states and the timeout exponent helper.
package sd_cmd_sequencer_pkg;

  localparam int unsigned CmdCrcChkBit = 3;
  localparam int unsigned CmdIdxChkBit = 4;
  localparam int unsigned CmdIdxLsb    = 8;
  localparam int unsigned CmdIdxMsb    = 13;

  localparam logic [1:0] RspNone = 2'b00;
  localparam logic [1:0] RspR136 = 2'b01;
  localparam logic [1:0] RspR48  = 2'b10;
  localparam logic [1:0] RspR48b = 2'b11;

  localparam int unsigned ErrTimeoutBit = 0;
  localparam int unsigned ErrCrcBit     = 1;
  localparam int unsigned ErrEndBit     = 2;
  localparam int unsigned ErrIdxBit     = 3;

  localparam int unsigned NormCmdCompleteBit = 0;
  localparam int unsigned NormErrSummaryBit  = 15;

  localparam int unsigned TcMax = 14;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StComplete
  } state_e;

  // Exponent of the response timeout: base + tc, with tc saturating at TcMax.
  function automatic int unsigned timeout_shift(input int unsigned base, input logic [3:0] tc);
    int unsigned tc_clamped;
    tc_clamped = (tc > 4'(TcMax)) ? TcMax : {28'd0, tc};
    return base + tc_clamped;
  endfunction

endpackage

// File: rtl/sd_cmd_timeout_counter.sv
// Response timeout counter: cleared on request, counts while enabled, flags when the limit
// is reached and then holds.
module sd_cmd_timeout_counter #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  assign o_expired = (r_count >= i_limit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Issues one SD command per COMMAND register write, waits for the PHY response or timeout,
// evaluates errors and writes response and interrupt status back to the register file.
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_BASE = 13,
  parameter int unsigned CNT_W        = 28
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_strobe,
  input  logic [15:0]  command,
  input  logic [31:0]  argument,
  input  logic [15:0]  timeout_control,
  input  logic         cmd_line_reset,
  input  logic         reg_busy,
  input  logic         phy_ack,
  input  logic         phy_done,
  input  logic [127:0] phy_resp,
  input  logic         phy_crc_err,
  input  logic         phy_end_err,
  output logic         cmd_start,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic [1:0]   resp_type,
  output logic         cmd_inhibit,
  output logic         command_complete,
  output logic [127:0] response_o,
  output logic [15:0]  error_interrupt_status_o,
  output logic [15:0]  normal_interrupt_status_o
);

  state_e           r_state;
  state_e           w_state_next;
  logic [5:0]       r_cmd_index;
  logic [31:0]      r_cmd_arg;
  logic [1:0]       r_resp_type;
  logic             r_crc_chk;
  logic             r_idx_chk;
  logic [CNT_W-1:0] r_limit;
  logic [127:0]     r_response;
  logic [15:0]      r_err_status;
  logic [15:0]      r_norm_status;

  logic             w_accept;
  logic             w_finish;
  logic             w_expired;
  logic             w_cnt_clear;
  logic             w_cnt_enable;
  logic [CNT_W-1:0] w_limit;
  logic [15:0]      w_err;
  logic [15:0]      w_norm;
  logic [127:0]     w_resp;
  logic             w_unused;

  assign w_unused = ^{timeout_control[15:4], command[15:14], command[7:5], command[2],
                      phy_resp[7:0]};

  assign w_accept = (r_state == StIdle) && cmd_strobe && !cmd_line_reset;
  assign w_finish = (r_state == StWait) && !cmd_line_reset && (phy_done || w_expired);
  assign w_limit  = CNT_W'(1) << timeout_shift(TIMEOUT_BASE, timeout_control[3:0]);

  assign w_cnt_clear  = (r_state != StWait) || cmd_line_reset;
  assign w_cnt_enable = (r_state == StWait) && (r_resp_type != RspNone);

  sd_cmd_timeout_counter #(
    .CNT_W(CNT_W)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_enable),
    .i_limit  (r_limit),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:     if (cmd_strobe) w_state_next = StIssue;
      StIssue:    if (phy_ack) w_state_next = StWait;
      StWait:     if (phy_done || w_expired) w_state_next = StComplete;
      StComplete: if (!reg_busy) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
    if (cmd_line_reset) w_state_next = StIdle;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_resp_type <= '0;
      r_crc_chk   <= 1'b0;
      r_idx_chk   <= 1'b0;
      r_limit     <= '0;
    end else if (w_accept) begin
      r_cmd_index <= command[CmdIdxMsb:CmdIdxLsb];
      r_cmd_arg   <= argument;
      r_resp_type <= command[1:0];
      r_crc_chk   <= command[CmdCrcChkBit];
      r_idx_chk   <= command[CmdIdxChkBit];
      r_limit     <= w_limit;
    end
  end

  // A response arriving on the expiry cycle takes priority: no timeout is flagged.
  always_comb begin
    w_err  = '0;
    w_norm = '0;
    w_resp = r_response;
    if (phy_done) begin
      w_err[ErrCrcBit] = phy_crc_err & r_crc_chk;
      w_err[ErrEndBit] = phy_end_err;
      if (r_resp_type == RspR48 || r_resp_type == RspR48b) begin
        w_err[ErrIdxBit] = r_idx_chk & (phy_resp[45:40] != r_cmd_index);
      end
      case (r_resp_type)
        RspR136:         w_resp = {8'h00, phy_resp[127:8]};
        RspR48, RspR48b: w_resp = {96'b0, phy_resp[39:8]};
        default:         w_resp = r_response;
      endcase
    end else begin
      w_err[ErrTimeoutBit] = 1'b1;
    end
    w_norm[NormCmdCompleteBit] = 1'b1;
    w_norm[NormErrSummaryBit]  = |w_err[3:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_response    <= '0;
      r_err_status  <= '0;
      r_norm_status <= '0;
    end else if (w_finish) begin
      r_response    <= w_resp;
      r_err_status  <= w_err;
      r_norm_status <= w_norm;
    end
  end

  assign cmd_start                 = (r_state == StIssue);
  assign cmd_inhibit               = (r_state != StIdle);
  assign command_complete          = (r_state == StComplete);
  assign cmd_index                 = r_cmd_index;
  assign cmd_arg                   = r_cmd_arg;
  assign resp_type                 = r_resp_type;
  assign response_o                = r_response;
  assign error_interrupt_status_o  = r_err_status;
  assign normal_interrupt_status_o = r_norm_status;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: R48/R136 paths, timeout, error flags, busy write-back
// and abort/reset behaviour.
module tb_sd_cmd_sequencer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_strobe = 1'b0;
  logic [15:0]  command = '0;
  logic [31:0]  argument = '0;
  logic [15:0]  timeout_control = '0;
  logic         cmd_line_reset = 1'b0;
  logic         reg_busy = 1'b0;
  logic         phy_ack = 1'b0;
  logic         phy_done = 1'b0;
  logic [127:0] phy_resp = '0;
  logic         phy_crc_err = 1'b0;
  logic         phy_end_err = 1'b0;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         cmd_inhibit;
  logic         command_complete;
  logic [127:0] response_o;
  logic [15:0]  err_st;
  logic [15:0]  norm_st;

  int n_checks = 0;
  int n_pass   = 0;

  sd_cmd_sequencer dut (
    .clock                    (clock),
    .reset                    (reset),
    .cmd_strobe               (cmd_strobe),
    .command                  (command),
    .argument                 (argument),
    .timeout_control          (timeout_control),
    .cmd_line_reset           (cmd_line_reset),
    .reg_busy                 (reg_busy),
    .phy_ack                  (phy_ack),
    .phy_done                 (phy_done),
    .phy_resp                 (phy_resp),
    .phy_crc_err              (phy_crc_err),
    .phy_end_err              (phy_end_err),
    .cmd_start                (cmd_start),
    .cmd_index                (cmd_index),
    .cmd_arg                  (cmd_arg),
    .resp_type                (resp_type),
    .cmd_inhibit              (cmd_inhibit),
    .command_complete         (command_complete),
    .response_o               (response_o),
    .error_interrupt_status_o (err_st),
    .normal_interrupt_status_o(norm_st)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [15:0] cmd, input logic [31:0] arg, input logic [3:0] tc);
    command         = cmd;
    argument        = arg;
    timeout_control = {12'h000, tc};
    cmd_strobe      = 1'b1;
    tick();
    cmd_strobe      = 1'b0;
  endtask

  task automatic ack();
    phy_ack = 1'b1;
    tick();
    phy_ack = 1'b0;
  endtask

  task automatic done(input logic [127:0] resp, input logic crc, input logic endb);
    phy_resp    = resp;
    phy_crc_err = crc;
    phy_end_err = endb;
    phy_done    = 1'b1;
    tick();
    phy_done    = 1'b0;
    phy_crc_err = 1'b0;
    phy_end_err = 1'b0;
  endtask

  function automatic logic [127:0] r48(input logic [5:0] idx, input logic [31:0] card);
    logic [127:0] r;
    r          = '0;
    r[45:40]   = idx;
    r[39:8]    = card;
    r[7:0]     = 8'hA5;
    return r;
  endfunction

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if (cmd_start !== 1'b0 || cmd_inhibit !== 1'b0 || command_complete !== 1'b0)
      $display("FAIL reset_ctrl: got start=%b inh=%b cc=%b want 0 0 0", cmd_start, cmd_inhibit,
               command_complete); else n_pass++;
    n_checks++; if ({cmd_index, cmd_arg, resp_type} !== 40'h0)
      $display("FAIL reset_latch: got %h want 0", {cmd_index, cmd_arg, resp_type}); else n_pass++;
    n_checks++; if (response_o !== 128'h0 || err_st !== 16'h0 || norm_st !== 16'h0)
      $display("FAIL reset_status: got %h %h %h want 0", response_o, err_st, norm_st);
      else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_r48();
    issue(16'h081A, 32'h1234_5678, 4'd0);
    n_checks++; if (cmd_start !== 1'b1 || cmd_inhibit !== 1'b1)
      $display("FAIL r48_issue: got start=%b inh=%b want 1 1", cmd_start, cmd_inhibit);
      else n_pass++;
    n_checks++; if (cmd_index !== 6'd8 || cmd_arg !== 32'h1234_5678 || resp_type !== 2'b10)
      $display("FAIL r48_latch: got idx=%0d arg=%h rt=%b want 8 12345678 10", cmd_index, cmd_arg,
               resp_type); else n_pass++;
    tick();
    n_checks++; if (cmd_start !== 1'b1)
      $display("FAIL r48_start_held: got %b want 1", cmd_start); else n_pass++;
    ack();
    n_checks++; if (cmd_start !== 1'b0)
      $display("FAIL r48_start_drop: got %b want 0", cmd_start); else n_pass++;
    tick();
    done(r48(6'd8, 32'h0000_01AA), 1'b0, 1'b0);
    n_checks++; if (command_complete !== 1'b1 || response_o !== 128'h1AA)
      $display("FAIL r48_complete: got cc=%b resp=%h want 1 1aa", command_complete, response_o);
      else n_pass++;
    n_checks++; if (err_st !== 16'h0000 || norm_st !== 16'h0001)
      $display("FAIL r48_status: got err=%h norm=%h want 0000 0001", err_st, norm_st);
      else n_pass++;
    tick();
    n_checks++; if (command_complete !== 1'b0 || cmd_inhibit !== 1'b0 || response_o !== 128'h1AA)
      $display("FAIL r48_after: got cc=%b inh=%b resp=%h want 0 0 1aa", command_complete,
               cmd_inhibit, response_o); else n_pass++;
  endtask

  task automatic test_timeout();
    int k;
    issue(16'h0002, 32'h0, 4'd0);
    ack();
    k = 0;
    while (command_complete !== 1'b1 && k < 9000) begin
      tick();
      k++;
    end
    n_checks++; if (k < 8190 || k > 8196)
      $display("FAIL timeout_latency: got %0d clocks want about 8193", k); else n_pass++;
    n_checks++; if (err_st !== 16'h0001 || norm_st !== 16'h8001)
      $display("FAIL timeout_status: got err=%h norm=%h want 0001 8001", err_st, norm_st);
      else n_pass++;
    tick();
  endtask

  task automatic test_idx_crc();
    issue(16'h111A, 32'h0, 4'd3);
    ack();
    done(r48(6'd3, 32'hDEAD_BEEF), 1'b1, 1'b0);
    n_checks++; if (err_st !== 16'h000A || norm_st !== 16'h8001)
      $display("FAIL idx_crc_on: got err=%h norm=%h want 000a 8001", err_st, norm_st);
      else n_pass++;
    tick();
    issue(16'h1102, 32'h0, 4'd3);
    ack();
    done(r48(6'd3, 32'hDEAD_BEEF), 1'b1, 1'b0);
    n_checks++; if (err_st !== 16'h0000 || norm_st !== 16'h0001)
      $display("FAIL idx_crc_off: got err=%h norm=%h want 0000 0001", err_st, norm_st);
      else n_pass++;
    tick();
    issue(16'h1102, 32'h0, 4'd3);
    ack();
    done(r48(6'd17, 32'h0), 1'b0, 1'b1);
    n_checks++; if (err_st !== 16'h0004 || norm_st !== 16'h8001)
      $display("FAIL end_bit: got err=%h norm=%h want 0004 8001", err_st, norm_st); else n_pass++;
    tick();
  endtask

  task automatic test_r136_busy();
    int cnt;
    issue(16'h0219, 32'h0, 4'd0);
    ack();
    reg_busy = 1'b1;
    done({128{1'b1}}, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (command_complete === 1'b1) cnt++;
      tick();
    end
    reg_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (command_complete === 1'b1) cnt++;
      tick();
    end
    n_checks++; if (cnt !== 4)
      $display("FAIL r136_cc_cycles: got %0d want 4", cnt); else n_pass++;
    n_checks++; if (response_o !== {8'h00, {120{1'b1}}})
      $display("FAIL r136_resp: got %h want 00ff..ff", response_o); else n_pass++;
    n_checks++; if (err_st !== 16'h0000 || norm_st !== 16'h0001 || cmd_inhibit !== 1'b0)
      $display("FAIL r136_status: got err=%h norm=%h inh=%b want 0000 0001 0", err_st, norm_st,
               cmd_inhibit); else n_pass++;
  endtask

  task automatic test_ignored_strobe();
    issue(16'h0C1A, 32'h0000_0C0C, 4'd0);
    ack();
    issue(16'h151A, 32'h0000_1515, 4'd0);
    n_checks++; if (cmd_index !== 6'd12 || cmd_arg !== 32'h0000_0C0C)
      $display("FAIL ignored_latch: got idx=%0d arg=%h want 12 00000c0c", cmd_index, cmd_arg);
      else n_pass++;
    n_checks++; if (cmd_start !== 1'b0 || cmd_inhibit !== 1'b1 || command_complete !== 1'b0)
      $display("FAIL ignored_state: got start=%b inh=%b cc=%b want 0 1 0", cmd_start, cmd_inhibit,
               command_complete); else n_pass++;
    done(r48(6'd12, 32'h0000_0777), 1'b0, 1'b0);
    n_checks++; if (err_st !== 16'h0000 || response_o !== 128'h777)
      $display("FAIL ignored_done: got err=%h resp=%h want 0000 777", err_st, response_o);
      else n_pass++;
    tick();
  endtask

  task automatic test_aborts();
    int k;
    issue(16'h071A, 32'h0, 4'd0);
    ack();
    done(r48(6'd7, 32'hCAFE_0007), 1'b1, 1'b0);
    n_checks++; if (err_st !== 16'h0002 || norm_st !== 16'h8001)
      $display("FAIL crc_only: got err=%h norm=%h want 0002 8001", err_st, norm_st); else n_pass++;
    tick();
    issue(16'h091A, 32'h0, 4'd0);
    cmd_line_reset = 1'b1;
    tick();
    cmd_line_reset = 1'b0;
    n_checks++; if (cmd_start !== 1'b0 || cmd_inhibit !== 1'b0 || command_complete !== 1'b0)
      $display("FAIL abort_ctrl: got start=%b inh=%b cc=%b want 0 0 0", cmd_start, cmd_inhibit,
               command_complete); else n_pass++;
    n_checks++; if (err_st !== 16'h0002 || norm_st !== 16'h8001 || response_o !== 128'hCAFE_0007)
      $display("FAIL abort_keep: got err=%h norm=%h resp=%h want 0002 8001 cafe0007", err_st,
               norm_st, response_o); else n_pass++;
    tick();
    issue(16'h0A1A, 32'hAAAA_5555, 4'd2);
    ack();
    tick();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (cmd_inhibit !== 1'b0 || cmd_start !== 1'b0 || command_complete !== 1'b0 ||
                    {cmd_index, cmd_arg, resp_type} !== 40'h0)
      $display("FAIL async_ctrl: got inh=%b idx=%0d arg=%h want 0 0 0", cmd_inhibit, cmd_index,
               cmd_arg); else n_pass++;
    n_checks++; if (response_o !== 128'h0 || err_st !== 16'h0 || norm_st !== 16'h0)
      $display("FAIL async_status: got %h %h %h want 0", response_o, err_st, norm_st);
      else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    issue(16'h051A, 32'h0, 4'd0);
    ack();
    k = 0;
    while (command_complete !== 1'b1 && k < 8192) begin
      tick();
      k++;
    end
    n_checks++; if (command_complete !== 1'b0)
      $display("FAIL coincide_early: got cc=%b after %0d clocks want 0", command_complete, k);
      else n_pass++;
    done(r48(6'd5, 32'h5A5A_5A5A), 1'b0, 1'b0);
    n_checks++; if (command_complete !== 1'b1 || err_st !== 16'h0000 || norm_st !== 16'h0001)
      $display("FAIL coincide_status: got cc=%b err=%h norm=%h want 1 0000 0001",
               command_complete, err_st, norm_st); else n_pass++;
    n_checks++; if (response_o !== 128'h5A5A_5A5A)
      $display("FAIL coincide_resp: got %h want 5a5a5a5a", response_o); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_r48();
    test_timeout();
    test_idx_crc();
    test_r136_busy();
    test_ignored_strobe();
    test_aborts();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
